// File: rtl/mem_arbiter_ctrl.sv
// Cache-to-memory responder: arbitrates an icache read port and a dcache read/write port onto one RAM port.
// Optional statistics counters (icount, dcount, errcount) are built when MEMCTRL_STATS_EN is defined.
module mem_arbiter_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memerr,
`ifdef MEMCTRL_STATS_EN
    output logic [31:0]       icount,
    output logic [31:0]       dcount,
    output logic [15:0]       errcount,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds its request until its wait is 0; wait=0 and the load data
    // are valid in the same cycle the RAM reports ACCESS, and the FSM returns to IDLE.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_t;

    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [DATA_W-1:0] iload_q, iload_d;
    logic [DATA_W-1:0] dload_q, dload_d;
    logic              d_req;
    logic              i_done;
    logic              d_done;
    logic              err_evt;

`ifdef MEMCTRL_STATS_EN
    logic [31:0] icount_q, icount_d;
    logic [31:0] dcount_q, dcount_d;
    logic [15:0] errcount_q, errcount_d;
`endif

    assign d_req = dREN | dWEN;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        memerr   = 1'b0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        err_evt  = 1'b0;

        case (state_q)
            IDLE: begin
                // After MAX_DSTREAK dcache wins against a waiting icache, icache gets one turn.
                if (d_req && !(iREN && streak_q == STREAK_MAX)) begin
                    state_d = DSERV;
                end else if (iREN) begin
                    state_d = ISERV;
                end
            end
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = !dWEN;
                    if (ramstate == RS_ACCESS) begin
                        dwait   = 1'b0;
                        d_done  = 1'b1;
                        dload_d = ramload;
                        state_d = IDLE;
                    end else if (ramstate == RS_ERROR) begin
                        memerr  = 1'b1;
                        err_evt = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == RS_ACCESS) begin
                        iwait   = 1'b0;
                        i_done  = 1'b1;
                        iload_d = ramload;
                        state_d = IDLE;
                    end else if (ramstate == RS_ERROR) begin
                        memerr  = 1'b1;
                        err_evt = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!iREN || i_done) begin
            streak_d = '0;
        end else if (d_done && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    assign iload     = iload_d;
    assign dload     = dload_d;
    assign dbg_state = state_q;

`ifdef MEMCTRL_STATS_EN
    always_comb begin
        icount_d   = i_done  ? icount_q + 32'd1   : icount_q;
        dcount_d   = d_done  ? dcount_q + 32'd1   : dcount_q;
        errcount_d = err_evt ? errcount_q + 16'd1 : errcount_q;
    end

    assign icount   = icount_q;
    assign dcount   = dcount_q;
    assign errcount = errcount_q;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            iload_q    <= '0;
            dload_q    <= '0;
`ifdef MEMCTRL_STATS_EN
            icount_q   <= '0;
            dcount_q   <= '0;
            errcount_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
`ifdef MEMCTRL_STATS_EN
            icount_q   <= icount_d;
            dcount_q   <= dcount_d;
            errcount_q <= errcount_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed scenarios followed by randomized traffic against a transaction-level model of the arbiter.
module tb_mem_arbiter_ctrl;

    localparam int MAXS = 4;
    localparam logic [1:0] RS_FREE   = 2'b00;
    localparam logic [1:0] RS_BUSY   = 2'b01;
    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0]  dbg_state;
`ifdef MEMCTRL_STATS_EN
    logic [31:0] icount, dcount;
    logic [15:0] errcount;
`endif

    int checks   = 0;
    int failures = 0;

    mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr),
`ifdef MEMCTRL_STATS_EN
        .icount(icount), .dcount(dcount), .errcount(errcount),
`endif
        .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic drive_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    // Behavioural model state for the randomized phase
    logic [31:0] mem [16];
    int          owner;      // 0 none, 1 dcache, 2 icache
    int          d_run;      // dcache completions since icache was last served while it waited
    int          busy_left;
    int          outcome;    // 0 no completion, 1 access, 2 error
    bit          i_pend, d_pend, d_wr, d_both;
    logic [3:0]  i_idx, d_idx;
    logic [31:0] d_data;
    logic [31:0] exp_iload, exp_dload, e_addr;
    bit          e_ren, e_wen;
    int          icnt, dcnt, ecnt;
    logic [9:0]  seq;
    int          ncomp;

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;

        // Reset values
        drive_edge();
        drive_edge();
        sample();
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_memerr", memerr, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        drive_edge();
        nRST = 1'b1;
        sample();
        chk("rel_ramREN", ramREN, 0);

        // icache read, two BUSY cycles then ACCESS
        drive_edge();
        iREN = 1'b1; iaddr = 32'h40;
        sample();
        chk("ird_idle_ren", ramREN, 0);
        chk("ird_idle_iwait", iwait, 1);
        for (int k = 0; k < 2; k++) begin
            drive_edge();
            ramstate = RS_BUSY;
            sample();
            chk("ird_busy_ren", ramREN, 1);
            chk("ird_busy_addr", ramaddr, 32'h40);
            chk("ird_busy_iwait", iwait, 1);
        end
        drive_edge();
        ramstate = RS_ACCESS; ramload = 32'hDEADBEEF;
        sample();
        chk("ird_acc_ren", ramREN, 1);
        chk("ird_acc_addr", ramaddr, 32'h40);
        chk("ird_acc_iwait", iwait, 0);
        chk("ird_acc_iload", iload, 32'hDEADBEEF);
        chk("ird_acc_dwait", dwait, 1);
        drive_edge();
        iREN = 1'b0; ramstate = RS_FREE; ramload = 32'h0;
        sample();
        chk("ird_after_iwait", iwait, 1);
        chk("ird_after_ren", ramREN, 0);
        chk("ird_hold_iload", iload, 32'hDEADBEEF);

        // dcache write
        drive_edge();
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678;
        sample();
        chk("dwr_idle_wen", ramWEN, 0);
        drive_edge();
        ramstate = RS_ACCESS; ramload = 32'h5A5A5A5A;
        sample();
        chk("dwr_wen", ramWEN, 1);
        chk("dwr_ren", ramREN, 0);
        chk("dwr_addr", ramaddr, 32'h100);
        chk("dwr_store", ramstore, 32'h12345678);
        chk("dwr_dwait", dwait, 0);
        chk("dwr_iwait", iwait, 1);
        drive_edge();
        dWEN = 1'b0; ramstate = RS_FREE;
        sample();
        chk("dwr_after_dwait", dwait, 1);
        chk("dwr_after_wen", ramWEN, 0);

        // Both requesters held: grant order D,D,D,D,I,D,D,D,D,I
        drive_edge();
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h80; ramstate = RS_ACCESS;
        seq = '0; ncomp = 0;
        sample();
        chk("grant_first_iwait", iwait, 1);
        chk("grant_first_dwait", dwait, 1);
        for (int k = 0; k < 19; k++) begin
            drive_edge();
            sample();
            chk("grant_excl", {31'd0, iwait | dwait}, 1);
            if (!iwait || !dwait) begin
                seq = {seq[8:0], !iwait};
                ncomp++;
            end
        end
        chk("grant_count", ncomp, 10);
        chk("grant_order", {22'd0, seq}, {22'd0, 10'b0000100001});
        drive_edge();
        iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE;
        sample();
        chk("grant_end_ren", ramREN, 0);

        // ERROR on a dcache read, then retry
        drive_edge();
        dREN = 1'b1; daddr = 32'h200;
        sample();
        drive_edge();
        ramstate = RS_ERROR; ramload = 32'h0BAD0BAD;
        sample();
        chk("err_memerr", memerr, 1);
        chk("err_dwait", dwait, 1);
        chk("err_ren", ramREN, 1);
        chk("err_addr", ramaddr, 32'h200);
        drive_edge();
        ramstate = RS_FREE;
        sample();
        chk("err_pulse_end", memerr, 0);
        chk("err_idle_ren", ramREN, 0);
        chk("err_idle_dwait", dwait, 1);
        drive_edge();
        ramstate = RS_ACCESS; ramload = 32'hCAFEF00D;
        sample();
        chk("err_retry_dwait", dwait, 0);
        chk("err_retry_dload", dload, 32'hCAFEF00D);
        chk("err_retry_memerr", memerr, 0);

        // dcache drops its request mid-transaction
        drive_edge();
        daddr = 32'h300; ramstate = RS_FREE;
        sample();
        drive_edge();
        ramstate = RS_BUSY;
        sample();
        chk("drop_busy_ren", ramREN, 1);
        drive_edge();
        dREN = 1'b0; ramstate = RS_ACCESS; ramload = 32'h77777777;
        sample();
        chk("drop_ren", ramREN, 0);
        chk("drop_wen", ramWEN, 0);
        chk("drop_dwait", dwait, 1);
        chk("drop_dload_hold", dload, 32'hCAFEF00D);
        drive_edge();
        dREN = 1'b1;
        sample();
        chk("drop_idle_ren", ramREN, 0);
        chk("drop_idle_dwait", dwait, 1);
        drive_edge();
        ramload = 32'h31415926;
        sample();
        chk("drop_regrant_dwait", dwait, 0);
        chk("drop_regrant_dload", dload, 32'h31415926);
        drive_edge();
        dREN = 1'b0; ramstate = RS_FREE;
        sample();

        // Reset asserted in the middle of an icache transaction
        drive_edge();
        iREN = 1'b1; iaddr = 32'h44;
        sample();
        drive_edge();
        ramstate = RS_BUSY;
        sample();
        chk("rstmid_busy_ren", ramREN, 1);
        drive_edge();
        nRST = 1'b0; ramstate = RS_ACCESS; ramload = 32'h99999999;
        sample();
        chk("rstmid_ren", ramREN, 0);
        chk("rstmid_iwait", iwait, 1);
        chk("rstmid_iload", iload, 0);
        drive_edge();
        nRST = 1'b1; iREN = 1'b0; ramstate = RS_FREE;
        sample();
        chk("rstmid_after_ren", ramREN, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        owner = 0; d_run = 0; busy_left = 0;
        i_pend = 0; d_pend = 0; d_wr = 0; d_both = 0;
        i_idx = '0; d_idx = '0; d_data = '0;
        exp_iload = '0; exp_dload = '0;
        icnt = 0; dcnt = 0; ecnt = 0;
        drive_edge();
        nRST = 1'b0;
        drive_edge();
        nRST = 1'b1;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            drive_edge();
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                i_idx  = 4'($urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_wr   = 1'($urandom_range(0, 1));
                d_both = 1'($urandom_range(0, 1));
                d_idx  = 4'($urandom_range(0, 15));
                d_data = $urandom;
            end
            iREN   = i_pend;
            iaddr  = {26'd0, i_idx, 2'b00};
            dWEN   = d_pend && d_wr;
            dREN   = d_pend && (!d_wr || d_both);
            daddr  = {26'd0, d_idx, 2'b00};
            dstore = d_data;
            ramload = $urandom;
            outcome = 0;
            if (owner == 0) begin
                ramstate = 2'($urandom_range(0, 1));
            end else if (busy_left > 0) begin
                ramstate = 2'($urandom_range(0, 1));
                busy_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                ramstate = RS_ERROR;
                outcome  = 2;
            end else begin
                ramstate = RS_ACCESS;
                outcome  = 1;
                if (owner == 2) ramload = mem[i_idx];
                else if (!d_wr) ramload = mem[d_idx];
            end

            sample();
            e_ren  = (owner == 2) || (owner == 1 && !d_wr);
            e_wen  = (owner == 1) && d_wr;
            e_addr = (owner == 1) ? daddr : iaddr;
            if (owner == 2 && outcome == 1) exp_iload = ramload;
            if (owner == 1 && outcome == 1) exp_dload = ramload;
            chk("rnd_ramREN", ramREN, e_ren);
            chk("rnd_ramWEN", ramWEN, e_wen);
            chk("rnd_iwait", iwait, !(owner == 2 && outcome == 1));
            chk("rnd_dwait", dwait, !(owner == 1 && outcome == 1));
            chk("rnd_memerr", memerr, (owner != 0 && outcome == 2));
            chk("rnd_iload", iload, exp_iload);
            chk("rnd_dload", dload, exp_dload);
            if (owner != 0) chk("rnd_ramaddr", ramaddr, e_addr);
            if (owner == 1) chk("rnd_ramstore", ramstore, d_data);

            if (owner == 0) begin
                if (d_pend && !(i_pend && d_run >= MAXS)) owner = 1;
                else if (i_pend) owner = 2;
                busy_left = $urandom_range(0, 3);
            end else if (outcome == 1) begin
                if (owner == 1) begin
                    if (d_wr) mem[d_idx] = d_data;
                    d_pend = 0;
                    dcnt++;
                    if (i_pend) d_run++;
                end else begin
                    i_pend = 0;
                    d_run  = 0;
                    icnt++;
                end
                owner = 0;
            end else if (outcome == 2) begin
                ecnt++;
                owner = 0;
            end
            if (!iREN) d_run = 0;
        end

`ifdef MEMCTRL_STATS_EN
        chk("stat_icount", icount, icnt);
        chk("stat_dcount", dcount, dcnt);
        chk("stat_errcount", {16'd0, errcount}, ecnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
